// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The cache uses the slave view; the fetch stage / memory model drive the master view.
interface icache_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) ();
   logic                  instEn;
   logic [ADDR_WIDTH-1:0] instAddr;
   logic                  hit;
   logic [INST_WIDTH-1:0] cacheInst;
   logic                  memReqEn;
   logic [ADDR_WIDTH-1:0] memReqAddr;
   logic                  memInstOutEn;
   logic [INST_WIDTH-1:0] memInst;
   logic                  flush;
   logic [31:0]           hitCnt;
   logic [31:0]           missCnt;

   modport slave (
      input  instEn, instAddr, memInstOutEn, memInst, flush,
      output hit, cacheInst, memReqEn, memReqAddr, hitCnt, missCnt
   );

   modport master (
      output instEn, instAddr, memInstOutEn, memInst, flush,
      input  hit, cacheInst, memReqEn, memReqAddr, hitCnt, missCnt
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hit path,
// single outstanding miss to memory, global flush and hit/miss counters.
module icache #(
   parameter int INDEX_BITS = 7,
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) (
   input logic      clk,
   input logic      rst,
   icache_if.slave  bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [LINES-1:0]      r_valid;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [INST_WIDTH-1:0] r_data [LINES];
   logic [ADDR_WIDTH-1:0] r_missAddr;
   logic [31:0]           r_hitCnt;
   logic [31:0]           r_missCnt;

   logic [INDEX_BITS-1:0] w_idx;
   logic [INDEX_BITS-1:0] w_fillIdx;
   logic [TAG_BITS-1:0]   w_tag;
   logic [TAG_BITS-1:0]   w_fillTag;
   logic                  w_hit;
   logic                  w_missStart;
   logic                  w_fill;
   logic                  w_reqEn;
   logic [ADDR_WIDTH-1:0] w_reqAddr;

   assign w_idx     = bus.instAddr[INDEX_BITS+1:2];
   assign w_tag     = bus.instAddr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign w_fillIdx = r_missAddr[INDEX_BITS+1:2];
   assign w_fillTag = r_missAddr[ADDR_WIDTH-1:INDEX_BITS+2];

   assign w_hit = bus.instEn & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~rst;

   assign bus.hit        = w_hit;
   assign bus.cacheInst  = w_hit ? r_data[w_idx] : '0;
   assign bus.memReqEn   = w_reqEn;
   assign bus.memReqAddr = w_reqAddr;
   assign bus.hitCnt     = r_hitCnt;
   assign bus.missCnt    = r_missCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Flush beats both a new miss and a returning fill; reset forces the memory request quiet.
   always_comb begin
      w_nextState = r_state;
      w_reqEn     = 1'b0;
      w_reqAddr   = bus.instAddr;
      w_missStart = 1'b0;
      w_fill      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.instEn && !w_hit && !bus.flush) begin
               w_reqEn     = 1'b1;
               w_missStart = 1'b1;
               w_nextState = MISS;
            end
         end
         MISS: begin
            w_reqAddr = r_missAddr;
            if (bus.flush) begin
               w_nextState = IDLE;
            end else if (bus.memInstOutEn) begin
               w_fill      = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
      if (rst) begin
         w_reqEn     = 1'b0;
         w_reqAddr   = '0;
         w_missStart = 1'b0;
         w_fill      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= '0;
         r_missAddr <= '0;
         r_hitCnt   <= '0;
         r_missCnt  <= '0;
      end else begin
         if (bus.flush) begin
            r_valid <= '0;
         end else if (w_fill) begin
            r_valid[w_fillIdx] <= 1'b1;
         end
         if (w_missStart) begin
            r_missAddr <= bus.instAddr;
            r_missCnt  <= r_missCnt + 32'd1;
         end
         if (w_hit) begin
            r_hitCnt <= r_hitCnt + 32'd1;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_fillIdx]  <= w_fillTag;
         r_data[w_fillIdx] <= bus.memInst;
      end
   end
endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: each cycle's expected lookup/request outputs are queued
// when stimulus is driven and compared mid-cycle; counters are tracked by a small model.
module tb_icache;
   logic clk = 1'b0;
   logic rst = 1'b1;

   icache_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

   icache #(.INDEX_BITS(7), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        en;
      logic [31:0] addr;
      logic        mEn;
      logic [31:0] mInst;
      logic        fl;
      logic        eHit;
      logic [31:0] eInst;
      logic        eReq;
      logic [31:0] eReqAddr;
   } stim_t;

   typedef struct {
      string       name;
      logic        hit;
      logic [31:0] inst;
      logic        reqEn;
      logic [31:0] reqAddr;
   } exp_t;

   exp_t        sb[$];
   int          checkCnt = 0;
   int          passCnt  = 0;
   logic [31:0] expHitCnt  = 32'd0;
   logic [31:0] expMissCnt = 32'd0;

   function automatic stim_t mk(input string name, input logic en, input logic [31:0] addr,
                                input logic mEn, input logic [31:0] mInst, input logic fl,
                                input logic eHit, input logic [31:0] eInst,
                                input logic eReq, input logic [31:0] eReqAddr);
      stim_t s;
      s.name = name; s.en = en; s.addr = addr; s.mEn = mEn; s.mInst = mInst; s.fl = fl;
      s.eHit = eHit; s.eInst = eInst; s.eReq = eReq; s.eReqAddr = eReqAddr;
      return s;
   endfunction

   // Drive one cycle of inputs and queue what the cache must show during that cycle.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      bus.instEn       = s.en;
      bus.instAddr     = s.addr;
      bus.memInstOutEn = s.mEn;
      bus.memInst      = s.mInst;
      bus.flush        = s.fl;
      e.name    = s.name;
      e.hit     = s.eHit;
      e.inst    = s.eInst;
      e.reqEn   = s.eReq;
      e.reqAddr = s.eReqAddr;
      sb.push_back(e);
      if (s.eHit && !rst) expHitCnt++;
      if (s.eReq && !rst) expMissCnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      applyStimulus(mk("reset lookup", 1, 32'h4, 0, 0, 0, 0, 0, 0, 32'h0));
      @(negedge clk);
      e = sb.pop_front();
      checkCnt++;
      if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
         $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                  e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
      else passCnt++;
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== 64'd0)
         $display("[TB] FAIL reset counters: got hit=%0d miss=%0d, want 0/0", bus.hitCnt, bus.missCnt);
      else passCnt++;
      step();
      rst = 1'b0;
   endtask

   task automatic test_missFill();
      stim_t rows[$];
      exp_t  e;
      rows.push_back(mk("miss 0x4",     1, 32'h4, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
      rows.push_back(mk("fill 0x4",     0, 32'h4, 1, 32'h0010_0093, 0, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("hit 0x4",      1, 32'h4, 0, 32'h0,         0, 1, 32'h0010_0093, 0, 32'h4));
      rows.push_back(mk("idle mem ret", 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         0, 32'h0));
      rows.push_back(mk("hit 0x4 kept", 1, 32'h4, 0, 32'h0,         0, 1, 32'h0010_0093, 0, 32'h4));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL missFill counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   task automatic test_conflict();
      stim_t rows[$];
      exp_t  e;
      rows.push_back(mk("miss 0x204",   1, 32'h204, 0, 32'h0,         0, 0, 32'h0,         1, 32'h204));
      rows.push_back(mk("fill 0x204",   0, 32'h204, 1, 32'h0020_0113, 0, 0, 32'h0,         0, 32'h204));
      rows.push_back(mk("hit 0x204",    1, 32'h204, 0, 32'h0,         0, 1, 32'h0020_0113, 0, 32'h204));
      rows.push_back(mk("evicted 0x4",  1, 32'h4,   0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
      rows.push_back(mk("refill 0x4",   0, 32'h0,   1, 32'h0010_0093, 0, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("evicted 0x204",1, 32'h204, 0, 32'h0,         1, 0, 32'h0,         0, 32'h204));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL conflict counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   task automatic test_back_to_back();
      stim_t rows[$];
      exp_t  e;
      rows.push_back(mk("refill 0x4", 1, 32'h4, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4));
      rows.push_back(mk("fill 0x4",   0, 32'h4, 1, 32'h0010_0093, 0, 0, 32'h0, 0, 32'h4));
      for (int k = 0; k < 3; k++)
         rows.push_back(mk("b2b hit 0x4", 1, 32'h4, 0, 32'h0, 0, 1, 32'h0010_0093, 0, 32'h4));
      rows.push_back(mk("no request", 0, 32'h4, 0, 32'h0, 0, 0, 32'h0, 0, 32'h4));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL b2b counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   task automatic test_flush();
      stim_t rows[$];
      exp_t  e;
      rows.push_back(mk("miss 0x8",         1, 32'h8, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8));
      rows.push_back(mk("flush+fill",       0, 32'h8, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 32'h8));
      rows.push_back(mk("0x8 after flush",  1, 32'h8, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8));
      rows.push_back(mk("fill 0x8",         0, 32'h8, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h8));
      rows.push_back(mk("hit 0x8",          1, 32'h8, 0, 32'h0,         0, 1, 32'h1111_1111, 0, 32'h8));
      rows.push_back(mk("0x4 flushed",      1, 32'h4, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
      rows.push_back(mk("flush in MISS",    0, 32'h4, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("flush idle miss",  1, 32'h4, 0, 32'h0,         1, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("stayed idle",      1, 32'h4, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL flush counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   // Entered while a miss on 0x4 is pending; reset must abandon it.
   task automatic test_resetMidMiss();
      stim_t rows[$];
      exp_t  e;
      rst = 1'b1;
      expHitCnt  = 32'd0;
      expMissCnt = 32'd0;
      applyStimulus(mk("lookup in reset", 1, 32'h8, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0));
      #1;
      e = sb.pop_front();
      checkCnt++;
      if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, bus.hitCnt, bus.missCnt} !==
          {e.hit, e.inst, e.reqEn, e.reqAddr, 64'd0})
         $display("[TB] FAIL %s: got hit=%0b req=%0b addr=%h hitCnt=%0d missCnt=%0d, want all zero",
                  e.name, bus.hit, bus.memReqEn, bus.memReqAddr, bus.hitCnt, bus.missCnt);
      else passCnt++;
      step();
      rst = 1'b0;
      rows.push_back(mk("stale return",    0, 32'h0, 1, 32'hCAFE_F00D, 0, 0, 32'h0, 0, 32'h0));
      rows.push_back(mk("0x4 not written", 1, 32'h4, 0, 32'h0,         1, 0, 32'h0, 0, 32'h4));
      rows.push_back(mk("0x8 cleared",     1, 32'h8, 0, 32'h0,         0, 0, 32'h0, 1, 32'h8));
      rows.push_back(mk("flush back idle", 0, 32'h8, 0, 32'h0,         1, 0, 32'h0, 0, 32'h8));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL resetMidMiss counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   task automatic test_secondMiss();
      stim_t rows[$];
      exp_t  e;
      rows.push_back(mk("miss 0x4",        1, 32'h4,   0, 32'h0,         0, 0, 32'h0,         1, 32'h4));
      rows.push_back(mk("2nd miss 0x8",    1, 32'h8,   0, 32'h0,         0, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("0x204 in MISS",   1, 32'h204, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("fill to 0x4",     0, 32'h8,   1, 32'h0030_0193, 0, 0, 32'h0,         0, 32'h4));
      rows.push_back(mk("hit 0x4 new",     1, 32'h4,   0, 32'h0,         0, 1, 32'h0030_0193, 0, 32'h4));
      rows.push_back(mk("0x8 not filled",  1, 32'h8,   0, 32'h0,         0, 0, 32'h0,         1, 32'h8));
      foreach (rows[i]) begin
         applyStimulus(rows[i]);
         @(negedge clk);
         e = sb.pop_front();
         checkCnt++;
         if ({bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr} !== {e.hit, e.inst, e.reqEn, e.reqAddr})
            $display("[TB] FAIL %s: got hit=%0b inst=%h req=%0b addr=%h, want hit=%0b inst=%h req=%0b addr=%h",
                     e.name, bus.hit, bus.cacheInst, bus.memReqEn, bus.memReqAddr, e.hit, e.inst, e.reqEn, e.reqAddr);
         else passCnt++;
         step();
      end
      checkCnt++;
      if ({bus.hitCnt, bus.missCnt} !== {expHitCnt, expMissCnt})
         $display("[TB] FAIL secondMiss counters: got hit=%0d miss=%0d, want %0d/%0d",
                  bus.hitCnt, bus.missCnt, expHitCnt, expMissCnt);
      else passCnt++;
   endtask

   initial begin
      bus.instEn       = 1'b0;
      bus.instAddr     = 32'h0;
      bus.memInstOutEn = 1'b0;
      bus.memInst      = 32'h0;
      bus.flush        = 1'b0;
      test_reset();
      test_missFill();
      test_conflict();
      test_back_to_back();
      test_flush();
      test_resetMidMiss();
      test_secondMiss();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, passed=%0d of %0d", passCnt, checkCnt);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
